hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core. It consumes the decode-side source registers and the EX/MEM/WB-stage fields published by the ID/EX, EX/MEM and MEM/WB registers. It drives back the stall/flush controls of those registers and the EX-stage operand forwarding selects. It also owns a registered data-memory wait FSM with timeout, which freezes the pipeline while a load/store waits for `MemReadyM`.

## Interface
Parameters:
- `MEM_TIMEOUT`, 16 — WAIT-state cycles before a forced release; 0 disables the timeout.
- `PERF_W`, 32 — width of the performance counters (only with `HAZARD_PERF_EN`).

Ports:
- `clk` input 1 — single clock, rising edge.
- `reset` input 1 — asynchronous, active-low reset.
- `RS1D`, `RS2D` input 5 — decode-stage source registers.
- `RS1E`, `RS2E`, `RDE` input 5 — EX-stage sources and destination.
- `ResultSrcE` input 2 — EX result select; `2'b01` = load.
- `PCSrcE` input 1 — taken branch/jump resolved in EX.
- `RDM`, `RDW` input 5 — MEM/WB destinations.
- `RegWriteM`, `RegWriteW` input 1 — MEM/WB write enables.
- `MemReqM` input 1 — load/store present in MEM.
- `MemReadyM` input 1 — data memory done.
- `ForwardAE`, `ForwardBE` output 2 — 00 = regfile, 01 = WB result, 10 = MEM ALU result.
- `StallF`, `StallD`, `StallE`, `StallM` output 1 — hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- `FlushD`, `FlushE`, `FlushW` output 1 — bubble into IF/ID, ID/EX and MEM/WB.
- `MemTimeout` output 1 — one-cycle pulse on forced release.
- `PerfStall`, `PerfFlush`, `PerfLoadUse` output `PERF_W` — only with `HAZARD_PERF_EN`.

## Operation
- Forwarding (combinational), port A:
  - `ForwardAE`=10 if `RegWriteM` & `RDM`!=0 & `RDM`==`RS1E`.
  - Else 01 if `RegWriteW` & `RDW`!=0 & `RDW`==`RS1E`.
  - Else 00.
  - Port B uses the same rules with `RS2E`; MEM has priority over WB.
- Load-use: `lwStall` = (`ResultSrcE`==01) & `RDE`!=0 & (`RDE`==`RS1D` | `RDE`==`RS2D`).
- FSM states and transitions:
  - IDLE → WAIT when `MemReqM` & !`MemReadyM`.
  - WAIT → IDLE when `MemReadyM`.
  - WAIT → TIMEOUT when !`MemReadyM` & `cnt`==`MEM_TIMEOUT`-1 (only if `MEM_TIMEOUT`>0).
  - TIMEOUT → IDLE unconditionally.
- Wait counter `cnt`: clears on entry to WAIT and increments each WAIT cycle.
- `memStall` (combinational):
  - IDLE: `MemReqM` & !`MemReadyM`.
  - WAIT: !`MemReadyM`.
  - TIMEOUT: 0.
- `MemTimeout` = 1 only in TIMEOUT.
- Output equations:
  - `StallF` = `StallD` = `lwStall` | `memStall`.
  - `StallE` = `StallM` = `FlushW` = `memStall`.
  - `FlushD` = `PCSrcE` & !`memStall`.
  - `FlushE` = (`lwStall` | `PCSrcE`) & !`memStall`.
- Memory stall has priority over flushes. While frozen, `PCSrcE` is held in the ID/EX register, so the flush is applied in the first unfrozen cycle. No redirect is lost.
- Simultaneous `lwStall` & `PCSrcE`: `FlushE`=1 and `StallD`=1; the flushed path is discarded.

## Timing
- Forward, stall and flush outputs are combinational from inputs and the current state, valid in the same cycle.
- FSM and counters update on the rising `clk` edge.
- Reset (async assert, sync deassert by the system) forces:
  - state IDLE, `cnt`=0, perf counters 0;
  - `MemTimeout`=0.
  - The combinational outputs then follow the inputs; with all inputs 0, every output is 0.
- Request to a ready memory (`MemReadyM`=1 in the first cycle): 0 stall cycles.
- Ready arriving k cycles after the request: exactly k stall cycles.
- Memory never ready: 1 + `MEM_TIMEOUT` stall cycles, then one TIMEOUT cycle in which the instruction advances.
- Reset asserted mid-WAIT: immediate return to IDLE; stalls drop combinationally.

## Configuration
- Macro `HAZARD_PERF_EN`.
- Defined:
  - three saturating `PERF_W`-bit counters;
  - `PerfStall` increments each cycle `StallF`=1;
  - `PerfFlush` increments each cycle `FlushD`=1;
  - `PerfLoadUse` increments each cycle `lwStall`=1 & !`memStall`.
- Undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared package `riscv_pkg` holds:
  - `fwd_sel_t` (FWD_RF=00, FWD_WB=01, FWD_MEM=10);
  - `RESULT_SRC_LOAD`=2'b01;
  - `hazard_state_t` (IDLE, WAIT, TIMEOUT).
- One sub-module, `hazard_perf_cnt`: a generic saturating counter, instantiated three times under the macro.

## Test plan
- `RS1E`=5, `RDM`=5, `RegWriteM`=1, `RDW`=5, `RegWriteW`=1 → `ForwardAE`=10. With `RDM`=0 instead → `ForwardAE`=01. Writes to x0 never forward.
- `ResultSrcE`=01, `RDE`=7, `RS2D`=7 → `StallF`=`StallD`=`FlushE`=1 for one cycle, `FlushD`=0.
- `PCSrcE`=1, no load → `FlushD`=`FlushE`=1, no stalls.
- `MemReqM`=1 with `MemReadyM` low for 3 cycles, high on the 4th → `StallF`..`StallM` and `FlushW` high for exactly 3 cycles. `PCSrcE`=1 during the stall → `FlushD`/`FlushE` appear only in the release cycle.
- `MEM_TIMEOUT`=4, `MemReadyM` stuck at 0 → 5 stall cycles, then `MemTimeout`=1 for one cycle with all stalls 0, then IDLE. Assert `reset`=0 mid-WAIT in a second run → immediate release and `cnt`=0.
- With `HAZARD_PERF_EN`, `PERF_W`=4: 20 stall cycles → `PerfStall` saturates at 15.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the 5-stage RISC-V core: forwarding selects, result-source
// encodings and the hazard unit's data-memory wait FSM states.
package riscv_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WAIT    = 2'b01,
        TIMEOUT = 2'b10
    } hazard_state_t;

    // EX operand source: the youngest in-flight writer (MEM) wins over WB; x0 never forwards.
    function automatic fwd_sel_t fwd_select(
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w,
        input logic [4:0] rs
    );
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_WB;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Generic saturating event counter; sticks at all-ones instead of wrapping.
module hazard_perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualifying cycles, holding at the maximum value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: EX operand forwarding, load-use stall, branch
// flush and a data-memory wait FSM that freezes the pipeline until MemReadyM
// (or a forced release after MEM_TIMEOUT wait cycles; 0 = never).
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush/load-use counters.
//
// state   | meaning
// IDLE    | no outstanding memory wait
// WAIT    | load/store in MEM waiting for MemReadyM; pipeline frozen
// TIMEOUT | forced release for one cycle; MemTimeout pulses
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] RS1D,
    input  logic [4:0] RS2D,
    input  logic [4:0] RS1E,
    input  logic [4:0] RS2E,
    input  logic [4:0] RDE,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic [4:0] RDM,
    input  logic [4:0] RDW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       MemTimeout
`ifdef HAZARD_PERF_EN
    , output logic [PERF_W-1:0] PerfStall
    , output logic [PERF_W-1:0] PerfFlush
    , output logic [PERF_W-1:0] PerfLoadUse
`endif
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    hazard_state_t    state;
    hazard_state_t    state_next;
    logic [CNT_W-1:0] cnt;
    logic             mem_stall;
    logic             lw_stall;

    assign ForwardAE = fwd_select(RegWriteM, RDM, RegWriteW, RDW, RS1E);
    assign ForwardBE = fwd_select(RegWriteM, RDM, RegWriteW, RDW, RS2E);

    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RDE != 5'd0)
                      && ((RDE == RS1D) || (RDE == RS2D));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Wait counter: zero outside WAIT, so it is clear on every WAIT entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state != WAIT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (MemReqM && !MemReadyM) state_next = WAIT;
            end
            WAIT: begin
                if (MemReadyM) begin
                    state_next = IDLE;
                end else if ((MEM_TIMEOUT > 0) && (cnt == CNT_LAST)) begin
                    state_next = TIMEOUT;
                end
            end
            TIMEOUT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: in IDLE the stall is raised combinationally so a not-ready
    // first cycle already freezes the pipeline.
    always_comb begin
        mem_stall  = 1'b0;
        MemTimeout = 1'b0;
        unique case (state)
            IDLE:    mem_stall = MemReqM && !MemReadyM;
            WAIT:    mem_stall = !MemReadyM;
            TIMEOUT: MemTimeout = 1'b1;
            default: mem_stall = 1'b0;
        endcase
    end

    // Memory freeze overrides flushes; PCSrcE stays held in ID/EX, so the
    // redirect is applied in the first unfrozen cycle.
    assign StallF = lw_stall || mem_stall;
    assign StallD = lw_stall || mem_stall;
    assign StallE = mem_stall;
    assign StallM = mem_stall;
    assign FlushW = mem_stall;
    assign FlushD = PCSrcE && !mem_stall;
    assign FlushE = (lw_stall || PCSrcE) && !mem_stall;

`ifdef HAZARD_PERF_EN
    hazard_perf_cnt #(.W(PERF_W)) u_perf_stall (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .count (PerfStall)
    );

    hazard_perf_cnt #(.W(PERF_W)) u_perf_flush (
        .clk   (clk),
        .reset (reset),
        .inc   (FlushD),
        .count (PerfFlush)
    );

    hazard_perf_cnt #(.W(PERF_W)) u_perf_load_use (
        .clk   (clk),
        .reset (reset),
        .inc   (lw_stall && !mem_stall),
        .count (PerfLoadUse)
    );
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (MEM_TIMEOUT=4; PERF_W=4 when
// HAZARD_PERF_EN is defined). Expected output vectors are queued as stimulus
// is driven and popped for comparison at the falling edge.
module tb_hazard_unit;

    localparam int TO = 4;

    logic       clk;
    logic       reset;
    logic [4:0] RS1D, RS2D, RS1E, RS2E, RDE, RDM, RDW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
`ifdef HAZARD_PERF_EN
    logic [3:0] PerfStall, PerfFlush, PerfLoadUse;
`endif

    // {fa[1:0], fb[1:0], StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout}
    localparam logic [11:0] V_ZERO  = 12'b0000_0000_0000;
    localparam logic [11:0] V_STALL = 12'b0000_1111_0010;
    localparam logic [11:0] V_FLUSH = 12'b0000_0000_1100;
    localparam logic [11:0] V_TOUT  = 12'b0000_0000_0001;

    logic [11:0] obs;
    logic [11:0] exp_q[$];
    logic [11:0] e;
    int vectors = 0;
    int miscompares = 0;

    assign obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                  FlushD, FlushE, FlushW, MemTimeout};

    hazard_unit #(
        .MEM_TIMEOUT(TO)
`ifdef HAZARD_PERF_EN
        , .PERF_W(4)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .RS1D(RS1D), .RS2D(RS2D), .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RDM(RDM), .RDW(RDW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout)
`ifdef HAZARD_PERF_EN
        , .PerfStall(PerfStall), .PerfFlush(PerfFlush), .PerfLoadUse(PerfLoadUse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (RegWriteM && RDM != 0 && RDM == rs) return 2'b10;
        if (RegWriteW && RDW != 0 && RDW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Reference for the combinational outputs with the memory FSM idle.
    function automatic logic [11:0] m_idle();
        logic lw;
        lw = (ResultSrcE == 2'b01) && RDE != 0 && (RDE == RS1D || RDE == RS2D);
        return {m_fwd(RS1E), m_fwd(RS2E), lw, lw, 1'b0, 1'b0,
                PCSrcE, lw | PCSrcE, 1'b0, 1'b0};
    endfunction

    task automatic clear_inputs();
        RS1D = 0; RS2D = 0; RS1E = 0; RS2E = 0; RDE = 0; RDM = 0; RDW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        exp_q.push_back(V_ZERO);
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b required %b", obs, e);
        end
        vectors++;
        if (dut.cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d required 0", dut.cnt);
        end
        reset = 1'b1;
    endtask

    task automatic test_forwarding();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            RegWriteM = 1; RegWriteW = 1; RS1E = 5; RDW = 5;
            case (i)
                0: RDM = 5;
                1: RDM = 0;
                2: begin RDM = 0; RDW = 0; end
                3: begin RDM = 5; RegWriteM = 0; end
                4: begin RS2E = 5; RDM = 9; end
                default: begin
                    RS1D = 5'($urandom_range(0, 7)); RS2D = 5'($urandom_range(0, 7));
                    RS1E = 5'($urandom_range(0, 7)); RS2E = 5'($urandom_range(0, 7));
                    RDE  = 5'($urandom_range(0, 7)); RDM  = 5'($urandom_range(0, 7));
                    RDW  = 5'($urandom_range(0, 7));
                    RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
                    ResultSrcE = 2'($urandom); PCSrcE = 1'($urandom);
                end
            endcase
            case (i)
                0: exp_q.push_back({2'b10, 2'b00, 8'b0});
                1: exp_q.push_back({2'b01, 2'b00, 8'b0});
                2: exp_q.push_back(V_ZERO);
                3: exp_q.push_back({2'b01, 2'b00, 8'b0});
                4: exp_q.push_back({2'b01, 2'b01, 8'b0});
                default: exp_q.push_back(m_idle());
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL forwarding[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_load_use_branch();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            case (i)
                0: begin ResultSrcE = 2'b01; RDE = 7; RS2D = 7; exp_q.push_back(12'b0000_1100_0100); end
                1: exp_q.push_back(V_ZERO);
                2: begin ResultSrcE = 2'b01; RDE = 0; RS1D = 0; exp_q.push_back(V_ZERO); end
                3: begin ResultSrcE = 2'b10; RDE = 3; RS1D = 3; exp_q.push_back(V_ZERO); end
                4: begin PCSrcE = 1; exp_q.push_back(V_FLUSH); end
                5: begin PCSrcE = 1; ResultSrcE = 2'b01; RDE = 4; RS1D = 4;
                          exp_q.push_back(12'b0000_1100_1100); end
                default: exp_q.push_back(V_ZERO);
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL load_use_branch[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            case (i)
                0: begin MemReqM = 1; MemReadyM = 1; exp_q.push_back(V_ZERO); end
                1, 2, 3: begin MemReqM = 1; PCSrcE = 1; exp_q.push_back(V_STALL); end
                4: begin MemReqM = 1; MemReadyM = 1; PCSrcE = 1; exp_q.push_back(V_FLUSH); end
                default: exp_q.push_back(V_ZERO);
            endcase
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL mem_wait[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < TO + 3; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            if (i <= TO + 1) MemReqM = 1;
            if (i <= TO) exp_q.push_back(V_STALL);
            else if (i == TO + 1) exp_q.push_back(V_TOUT);
            else exp_q.push_back(V_ZERO);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL timeout[%0d]: got %b required %b", i, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            clear_inputs();
            MemReqM = 1;
            exp_q.push_back(V_STALL);
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                miscompares++;
                $display("FAIL reset_mid_wait_pre[%0d]: got %b required %b", i, obs, e);
            end
        end
        #1;
        reset = 1'b0;
        MemReqM = 0;
        exp_q.push_back(V_ZERO);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_mid_wait_release: got %b required %b", obs, e);
        end
        vectors++;
        if (dut.cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_wait_cnt: got %0d required 0", dut.cnt);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        MemReqM = 1; MemReadyM = 1;
        exp_q.push_back(V_ZERO);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (obs !== e) begin
            miscompares++;
            $display("FAIL reset_mid_wait_after: got %b required %b", obs, e);
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ResultSrcE = 2'b01; RDE = 3; RS1D = 3;
        repeat (20) @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        vectors++;
        if (PerfStall !== 4'd15) begin
            miscompares++;
            $display("FAIL perf_stall: got %0d required 15", PerfStall);
        end
        vectors++;
        if (PerfLoadUse !== 4'd15) begin
            miscompares++;
            $display("FAIL perf_load_use: got %0d required 15", PerfLoadUse);
        end
        vectors++;
        if (PerfFlush !== 4'd0) begin
            miscompares++;
            $display("FAIL perf_flush: got %0d required 0", PerfFlush);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        reset = 1'b0;
        test_reset();
        test_forwarding();
        test_load_use_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
